sa_core: RTL and testbench

Output-stationary ROWS×ROWS systolic matrix-multiply core: streams one 8-bit activation vector and one 8-bit weight vector per beat, accumulates every outer product in a PE grid, then drains the 32-bit results one array row per handshake. It sits between the operand buffers and the result writeback path of the accelerator.

---
 rtl/sa_pkg.sv | 19 +
 rtl/sa_pe.sv | 56 +++++
 rtl/sa_core.sv | 175 +++++++++++++++++
 tb/tb_sa_core.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// Shared widths, FSM state encoding and flush-length helper for the systolic core.
package sa_pkg;

  localparam int DW   = 8;
  localparam int ACCW = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DRAIN
  } sa_state_e;

  // The last beat needs 2*rows-1 extra edges to reach the far corner PE.
  function automatic int flush_len(input int rows);
    return 2 * rows - 1;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// One processing element: registers incoming operands and forwards them, and
// accumulates their product whenever the travelling valid bit is set.
module sa_pe
  import sa_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic [DW-1:0]   a_in,
  input  logic [DW-1:0]   w_in,
  input  logic            v_in,
  input  logic            clr,
  output logic [DW-1:0]   a_out,
  output logic [DW-1:0]   w_out,
  output logic            v_out,
  output logic [ACCW-1:0] acc_out
);

  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   w_q, w_d;
  logic            v_q, v_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [2*DW-1:0] prod;

  always_comb begin
    a_d   = a_in;
    w_d   = w_in;
    v_d   = v_in;
    prod  = a_q * w_q;
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (v_q) begin
      acc_d = acc_q + ACCW'(prod);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q   <= '0;
      w_q   <= '0;
      v_q   <= 1'b0;
      acc_q <= '0;
    end else begin
      a_q   <= a_d;
      w_q   <= w_d;
      v_q   <= v_d;
      acc_q <= acc_d;
    end
  end

  assign a_out   = a_q;
  assign w_out   = w_q;
  assign v_out   = v_q;
  assign acc_out = acc_q;

endmodule

// File: rtl/sa_core.sv
// Output-stationary ROWS x ROWS systolic matrix-multiply core: input skew,
// pass-control FSM, PE grid and row-at-a-time result drain.
module sa_core
  import sa_pkg::*;
#(
  parameter int ROWS = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [DW-1:0]   ainport    [0:ROWS-1],
  input  logic [DW-1:0]   winport    [0:ROWS-1],
  input  logic            inpvalid,
  input  logic            outread,
  output logic [ACCW-1:0] routport   [0:ROWS-1],
  output logic            rvalidport [0:ROWS-1]
);

  localparam int FLUSH_LEN = flush_len(ROWS);
  localparam int CW        = $clog2(FLUSH_LEN + 1);
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1;

  sa_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          accept;
  logic          clr;

  logic [DW-1:0] a_skew_q [ROWS][ROWS-1];
  logic [DW-1:0] a_skew_d [ROWS][ROWS-1];
  logic [DW-1:0] w_skew_q [ROWS][ROWS-1];
  logic [DW-1:0] w_skew_d [ROWS][ROWS-1];
  logic          v_skew_q [ROWS][ROWS-1];
  logic          v_skew_d [ROWS][ROWS-1];

  logic [DW-1:0]   a_row [ROWS];
  logic            v_row [ROWS];
  logic [DW-1:0]   w_col [ROWS];
  logic [DW-1:0]   a_bus [ROWS][ROWS];
  logic [DW-1:0]   w_bus [ROWS][ROWS];
  logic            v_bus [ROWS][ROWS];
  logic [DW-1:0]   a_nxt [ROWS][ROWS];
  logic [DW-1:0]   w_nxt [ROWS][ROWS];
  logic            v_nxt [ROWS][ROWS];
  logic [ACCW-1:0] acc   [ROWS][ROWS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    accept  = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (inpvalid) begin
          accept  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (inpvalid) begin
          accept = 1'b1;
        end else begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      FLUSH: begin
        if (cnt_q == CW'(FLUSH_LEN - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (outread) begin
          if (row_q == RW'(ROWS - 1)) begin
            clr     = 1'b1;
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row i (column j) sees its operand i (j) cycles late; stage k holds a k+1 cycle delay.
  always_comb begin
    a_skew_d = a_skew_q;
    w_skew_d = w_skew_q;
    v_skew_d = v_skew_q;
    for (int i = 0; i < ROWS; i++) begin
      a_skew_d[i][0] = ainport[i];
      w_skew_d[i][0] = winport[i];
      v_skew_d[i][0] = accept;
      for (int k = 1; k < ROWS - 1; k++) begin
        a_skew_d[i][k] = a_skew_q[i][k-1];
        w_skew_d[i][k] = w_skew_q[i][k-1];
        v_skew_d[i][k] = v_skew_q[i][k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      a_skew_q <= '{default: '0};
      w_skew_q <= '{default: '0};
      v_skew_q <= '{default: 1'b0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      a_skew_q <= a_skew_d;
      w_skew_q <= w_skew_d;
      v_skew_q <= v_skew_d;
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_edge
    if (gi == 0) begin : g_direct
      assign a_row[gi] = ainport[gi];
      assign v_row[gi] = accept;
      assign w_col[gi] = winport[gi];
    end else begin : g_skewed
      assign a_row[gi] = a_skew_q[gi][gi-1];
      assign v_row[gi] = v_skew_q[gi][gi-1];
      assign w_col[gi] = w_skew_q[gi][gi-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < ROWS; gj++) begin : g_col
      if (gj == 0) begin : g_a_in
        assign a_bus[gi][gj] = a_row[gi];
        assign v_bus[gi][gj] = v_row[gi];
      end else begin : g_a_fwd
        assign a_bus[gi][gj] = a_nxt[gi][gj-1];
        assign v_bus[gi][gj] = v_nxt[gi][gj-1];
      end
      if (gi == 0) begin : g_w_in
        assign w_bus[gi][gj] = w_col[gj];
      end else begin : g_w_fwd
        assign w_bus[gi][gj] = w_nxt[gi-1][gj];
      end

      sa_pe u_pe (
        .clk     (clk),
        .rstn    (rstn),
        .a_in    (a_bus[gi][gj]),
        .w_in    (w_bus[gi][gj]),
        .v_in    (v_bus[gi][gj]),
        .clr     (clr),
        .a_out   (a_nxt[gi][gj]),
        .w_out   (w_nxt[gi][gj]),
        .v_out   (v_nxt[gi][gj]),
        .acc_out (acc[gi][gj])
      );
    end
  end

  always_comb begin
    for (int j = 0; j < ROWS; j++) begin
      rvalidport[j] = (state_q == DRAIN);
      routport[j]   = (state_q == DRAIN) ? acc[row_q][j] : '0;
    end
  end

endmodule

// File: tb/tb_sa_core.sv
// Self-checking bench for sa_core: a bench-side outer-product model fills a
// scoreboard queue at the end of each pass; drained rows are popped and compared.
module tb_sa_core;

  localparam int ROWS = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  ainport    [0:ROWS-1];
  logic [7:0]  winport    [0:ROWS-1];
  logic        inpvalid;
  logic        outread;
  logic [31:0] routport   [0:ROWS-1];
  logic        rvalidport [0:ROWS-1];

  int errors = 0;
  int checks = 0;

  logic [31:0] model [ROWS][ROWS];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  sa_core #(.ROWS(ROWS)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .ainport    (ainport),
    .winport    (winport),
    .inpvalid   (inpvalid),
    .outread    (outread),
    .routport   (routport),
    .rvalidport (rvalidport)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < ROWS; j++)
        model[i][j] = '0;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < ROWS; i++) begin
      ainport[i] = 8'($urandom);
      winport[i] = 8'($urandom);
    end
  endtask

  task automatic send_beat(input logic [7:0] a [ROWS], input logic [7:0] w [ROWS]);
    for (int i = 0; i < ROWS; i++) begin
      ainport[i] = a[i];
      winport[i] = w[i];
    end
    inpvalid = 1'b1;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < ROWS; j++)
        model[i][j] = model[i][j] + 32'(a[i]) * 32'(w[j]);
    tick();
  endtask

  // Ends the pass, pushes the expected matrix and checks the flush latency.
  task automatic finish_pass(input bit glitch);
    int  n;
    bit  seen;
    inpvalid = 1'b0;
    for (int i = 0; i < ROWS; i++)
      for (int j = 0; j < ROWS; j++)
        exp_q.push_back(model[i][j]);
    clear_model();
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      tick();
      n++;
      if (rvalidport[0] === 1'b1) seen = 1'b1;
      if (glitch) begin
        randomize_data();
        inpvalid = 1'($urandom_range(0, 1));
      end
    end
    inpvalid = 1'b0;
    checks++;
    if (!seen || n != 2 * ROWS) begin
      errors++;
      $display("[TB] FAIL flush_latency: got %0d edges (seen=%0d), expected %0d", n, seen, 2 * ROWS);
    end
  endtask

  task automatic compare_row(input int r, input logic [31:0] exp_row [ROWS], input string tag);
    for (int j = 0; j < ROWS; j++) begin
      checks++;
      if (routport[j] !== exp_row[j]) begin
        errors++;
        $display("[TB] FAIL %s row%0d lane%0d: got %0d, expected %0d", tag, r, j, routport[j], exp_row[j]);
      end
    end
    checks++;
    for (int j = 0; j < ROWS; j++) begin
      if (rvalidport[j] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s rvalid row%0d lane%0d: got %b, expected 1", tag, r, j, rvalidport[j]);
        break;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int j = 0; j < ROWS; j++) begin
      checks++;
      if (rvalidport[j] !== 1'b0 || routport[j] !== 32'd0) begin
        errors++;
        $display("[TB] FAIL %s lane%0d: got valid=%b data=%0d, expected valid=0 data=0",
                 tag, j, rvalidport[j], routport[j]);
      end
    end
  endtask

  // Drains all rows; hold cycles stall row 0, pulse mode leaves a gap between handshakes.
  task automatic drain_pass(input int hold, input bit pulse, input bit glitch);
    logic [31:0] exp_row [ROWS];
    for (int r = 0; r < ROWS; r++) begin
      for (int j = 0; j < ROWS; j++)
        exp_row[j] = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      if (r == 0) begin
        for (int h = 0; h < hold; h++) begin
          compare_row(r, exp_row, "hold");
          if (glitch) begin
            randomize_data();
            inpvalid = 1'($urandom_range(0, 1));
          end
          tick();
        end
        inpvalid = 1'b0;
      end
      compare_row(r, exp_row, "drain");
      outread = 1'b1;
      tick();
      if (pulse) begin
        outread = 1'b0;
        tick();
      end
    end
    outread = 1'b0;
    check_idle_outputs("after_drain");
    outread = 1'b1;
    tick();
    outread = 1'b0;
    check_idle_outputs("idle_outread");
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      randomize_data();
      inpvalid = 1'($urandom_range(0, 1));
      outread  = 1'($urandom_range(0, 1));
      tick();
      check_idle_outputs("reset");
    end
    inpvalid = 1'b0;
    outread  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      tick();
      check_idle_outputs("post_reset_idle");
    end
  endtask

  task automatic test_single_beat();
    logic [7:0] a [ROWS];
    logic [7:0] w [ROWS];
    for (int i = 0; i < ROWS; i++) begin
      a[i] = 8'd3;
      w[i] = 8'd1;
    end
    send_beat(a, w);
    finish_pass(1'b0);
    drain_pass(0, 1'b0, 1'b0);
  endtask

  task automatic test_sum16();
    logic [7:0] a [ROWS];
    logic [7:0] w [ROWS];
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < ROWS; i++) begin
        a[i] = 8'(k % 16);
        w[i] = 8'd1;
      end
      send_beat(a, w);
    end
    finish_pass(1'b0);
    drain_pass(0, 1'b0, 1'b0);
  endtask

  task automatic test_outer();
    logic [7:0] a [ROWS];
    logic [7:0] w [ROWS];
    for (int i = 0; i < ROWS; i++) begin
      a[i] = 8'(i + 1);
      w[i] = 8'(i + 1);
    end
    send_beat(a, w);
    finish_pass(1'b0);
    drain_pass(0, 1'b0, 1'b0);
  endtask

  task automatic test_hold_pulse();
    logic [7:0] a [ROWS];
    logic [7:0] w [ROWS];
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < ROWS; i++) begin
        a[i] = 8'($urandom);
        w[i] = 8'($urandom);
      end
      send_beat(a, w);
    end
    finish_pass(1'b0);
    drain_pass(20, 1'b1, 1'b0);
  endtask

  task automatic test_max_glitch();
    logic [7:0] a [ROWS];
    logic [7:0] w [ROWS];
    for (int i = 0; i < ROWS; i++) begin
      a[i] = 8'd255;
      w[i] = 8'd255;
    end
    send_beat(a, w);
    send_beat(a, w);
    finish_pass(1'b1);
    drain_pass(6, 1'b0, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic [7:0] a [ROWS];
    logic [7:0] w [ROWS];
    for (int i = 0; i < ROWS; i++) begin
      a[i] = 8'd7;
      w[i] = 8'd9;
    end
    send_beat(a, w);
    send_beat(a, w);
    #2 rstn = 1'b0;
    clear_model();
    inpvalid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    for (int i = 0; i < ROWS; i++) begin
      a[i] = 8'd2;
      w[i] = 8'd2;
    end
    send_beat(a, w);
    finish_pass(1'b0);
    // Async reset taken mid-drain must drop valid before the next edge.
    #2 rstn = 1'b0;
    #1;
    check_idle_outputs("async_reset_drain");
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    tick();
    for (int i = 0; i < ROWS; i++) begin
      a[i] = 8'd1;
      w[i] = 8'd5;
    end
    send_beat(a, w);
    finish_pass(1'b0);
    drain_pass(0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a [ROWS];
    logic [7:0] w [ROWS];
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < ROWS; i++) begin
        a[i] = 8'(i + p + 1);
        w[i] = 8'(2 * i + 1);
      end
      send_beat(a, w);
      send_beat(w, a);
      finish_pass(1'b0);
      drain_pass(0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    inpvalid = 1'b0;
    outread  = 1'b0;
    for (int i = 0; i < ROWS; i++) begin
      ainport[i] = '0;
      winport[i] = '0;
    end
    clear_model();
    test_reset();
    test_single_beat();
    test_sum16();
    test_outer();
    test_hold_pulse();
    test_max_glitch();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
